chan_sel_mux: RTL and testbench
===============================

# chan_sel_mux

- Parametrised N-to-1 channel selector with a valid/ready handshake on every input channel and on the output, plus one registered output stage.
- It generalises the fixed 8-to-1 multiplexer to any channel count and data width.
- Two selection modes: an externally driven fixed select, or internal round-robin arbitration among valid channels.
- Sits between several producer streams and one shared consumer, such as a shared datapath or a debug/trace port.

## Interface
- N, 8, number of input channels; N ≥ 2, not necessarily a power of two.
- W, 8, data width per channel in bits; W ≥ 1.
- SELW, $clog2(N), width of the select and channel-ID fields; derived, not overridden.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high in any cycle.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel chosen in fixed mode; ignored in round-robin mode.
- out_data  output  W  registered output data.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  output register holds valid data.
- out_ready  input  1  consumer accepts data.

## Operation
- **Output register.** Two states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- **load_en** = !out_valid | out_ready. The register may load whenever it is empty or is being drained in the same cycle.
- **Grant, fixed mode:**
  - grant = sel when sel < N.
  - When sel ≥ N, no grant: in_ready = 0.
- **Grant, round-robin mode:**
  - grant = the first index g, starting at ptr and wrapping modulo N, with in_valid[g] = 1.
  - When no in_valid bit is set, no grant: in_ready = 0.
- **Ready.** in_ready[grant] = load_en. All other bits are 0.
  - In fixed mode, in_ready[sel] may be high while in_valid[sel] is low.
  - All in_ready bits are combinational from the current inputs and state.
- **Input transfer** happens when in_valid[grant] & in_ready[grant]. On that edge:
  - out_data ← channel grant data.
  - out_ch ← grant.
  - out_valid ← 1.
- **Output transfer** happens when out_valid & out_ready. If no input transfer occurs on the same edge, out_valid ← 0.
  - Simultaneous output and input transfer: the register reloads and stays FULL. No bubble.
- **Holding.** While out_valid & !out_ready, out_data and out_ch are held stable.
- **Pointer update.** ptr updates only on an input transfer made in round-robin mode: ptr ← (grant + 1) mod N, with correct wrap for non-power-of-two N.
  - Fixed-mode transfers do not change ptr.
- **Mode switching.** mode and sel are sampled combinationally each cycle. A change affects only the next grant, never data already in the output register.
- **Producer rule.** The producer must hold in_data/in_valid until its transfer completes. The block does not buffer unaccepted inputs.

## Timing
- **Reset values** (asynchronous on rst, immediate):
  - out_valid = 0, out_data = 0, out_ch = 0, ptr = 0.
  - in_ready = 0 for as long as rst is high.
- **First cycle after release:** out_valid = 0, so load_en = 1 and in_ready may rise combinationally.
- **Reset mid-operation:** data held in the output register is discarded. No output transfer is reported.
- **Latency:** one clock from input transfer to out_valid = 1 with that data.
- **Throughput:** one word per clock while out_ready stays high.
- **Round-robin fairness:** with all N channels valid and out_ready = 1, grants cycle ptr, ptr+1, …, and each channel is served exactly once per N transfers.
- **Backpressure:** out_ready = 0 with out_valid = 1 forces in_ready = 0 in the same cycle.

## Test plan
- **Reset / idle.** Assert rst mid-stream with out_valid = 1 -> out_valid, out_data, out_ch read 0 before the next clock edge, and in_ready = 0 while rst is high. Release with no valids -> out_valid stays 0.
- **Fixed mode (N = 8, W = 8).** mode = 0; sel = 3 then 7; in_data lanes = 8'h10+i; all valid; out_ready = 1 -> one cycle later out_data = 8'h13 with out_ch = 3, then 8'h17 with out_ch = 7. sel = 7 with only in_valid[2] set -> no transfer.
- **Round-robin, full load.** mode = 1; all 8 channels valid; out_ready = 1 -> out_ch sequence 0,1,…,7,0 on consecutive cycles with no bubbles.
- **Sparse round-robin and wrap.** N = 5; valid only on channels 1 and 4 -> out_ch 1,4,1,4; ptr wraps 4 → 0 correctly. sel = 6 in fixed mode -> in_ready = 0.
- **Backpressure.** out_ready low for 3 cycles while out_valid = 1 -> out_data and out_ch stable and in_ready = 0. Raise out_ready -> drain and reload on the same edge.
- **Mode switch.** Switch mode 1 → 0 while the output register is full -> the held word is delivered unchanged and the next grant equals sel. Switching back resumes from the stored ptr.

Source files
------------

// File: rtl/chan_sel_mux.sv
// N-to-1 channel selector with valid/ready on every channel and one registered output stage.
// The grant comes from an external select (fixed mode) or from a round-robin search over the valid channels.
module chan_sel_mux #(
  parameter  int N    = 8,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic [SELW-1:0] grant;
  logic [SELW-1:0] cand;
  logic            grant_valid;
  logic            load_en;
  logic            xfer_in;

  // ptr + k is always below 2N, so a single conditional subtract wraps it for any N.
  function automatic logic [SELW-1:0] wrap_idx(input int v);
    return (v >= N) ? SELW'(v - N) : SELW'(v);
  endfunction

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    cand        = '0;
    if (!mode) begin
      if (int'(sel) < N) begin
        grant_valid = 1'b1;
        grant       = sel;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = wrap_idx(int'(ptr_q) + k);
        if (!grant_valid && in_valid[cand]) begin
          grant_valid = 1'b1;
          grant       = cand;
        end
      end
    end
  end

  // Ready is forced low during reset even though the empty register would otherwise allow a load.
  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    in_ready = '0;
    if (grant_valid && load_en && !rst) in_ready[grant] = 1'b1;
  end

  assign xfer_in = grant_valid && load_en && in_valid[grant] && !rst;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer_in) begin
      out_data_d  = in_data[int'(grant)*W +: W];
      out_ch_d    = grant;
      out_valid_d = 1'b1;
      if (mode) ptr_d = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the processes are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_chan_sel_mux.sv
// Bench for chan_sel_mux: an N=8 and an N=5 instance share stimulus and are checked
// each cycle against a transaction-level model of the selector.
module tb_chan_sel_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data8;
  logic [7:0]  in_valid8;
  logic        mode;
  logic [2:0]  sel;
  logic        out_ready;

  logic [7:0] d8_in_ready, d8_out_data;
  logic [2:0] d8_out_ch;
  logic       d8_out_valid;
  logic [4:0] d5_in_ready;
  logic [7:0] d5_out_data;
  logic [2:0] d5_out_ch;
  logic       d5_out_valid;

  int vectors     = 0;
  int miscompares = 0;

  // Model state per instance: index 0 is N=8, index 1 is N=5.
  int       nch[2] = '{8, 5};
  bit       m_valid[2];
  bit [7:0] m_data[2];
  int       m_ch[2];
  int       m_ptr[2];

  always #5 clk = ~clk;

  chan_sel_mux #(.N(8), .W(8)) dut8 (
    .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8), .in_ready(d8_in_ready),
    .mode(mode), .sel(sel), .out_data(d8_out_data), .out_ch(d8_out_ch),
    .out_valid(d8_out_valid), .out_ready(out_ready)
  );

  chan_sel_mux #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst(rst), .in_data(in_data8[39:0]), .in_valid(in_valid8[4:0]), .in_ready(d5_in_ready),
    .mode(mode), .sel(sel), .out_data(d5_out_data), .out_ch(d5_out_ch),
    .out_valid(d5_out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
      m_ch[k]    = 0;
      m_ptr[k]   = 0;
    end
  endtask

  function automatic logic [31:0] ready_of(input int k);
    return (k == 0) ? 32'(d8_in_ready) : 32'(d5_in_ready);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_v8"},  32'(d8_out_valid), 32'(m_valid[0]));
    check({tag, "_d8"},  32'(d8_out_data),  32'(m_data[0]));
    check({tag, "_c8"},  32'(d8_out_ch),    32'(m_ch[0]));
    check({tag, "_v5"},  32'(d5_out_valid), 32'(m_valid[1]));
    check({tag, "_d5"},  32'(d5_out_data),  32'(m_data[1]));
    check({tag, "_c5"},  32'(d5_out_ch),    32'(m_ch[1]));
  endtask

  // One clock: inputs are already set; check readiness before the edge, outputs after it.
  task automatic step(input string tag);
    int  grant[2];
    bit  xfer[2];
    for (int k = 0; k < 2; k++) begin
      bit can_load;
      int n;
      n        = nch[k];
      can_load = !m_valid[k] || out_ready;
      grant[k] = -1;
      if (!mode) begin
        if (int'(sel) < n) grant[k] = int'(sel);
      end else begin
        for (int j = 0; j < n; j++) begin
          if (grant[k] < 0 && in_valid8[(m_ptr[k] + j) % n]) grant[k] = (m_ptr[k] + j) % n;
        end
      end
      xfer[k] = (grant[k] >= 0) && can_load && in_valid8[grant[k]];
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] exp_rdy;
      bit can_load;
      can_load = !m_valid[k] || out_ready;
      exp_rdy  = (grant[k] >= 0 && can_load) ? (32'd1 << grant[k]) : 32'd0;
      check({tag, (k == 0) ? "_rdy8" : "_rdy5"}, ready_of(k), exp_rdy);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (xfer[k]) begin
        m_valid[k] = 1'b1;
        m_data[k]  = in_data8[grant[k]*8 +: 8];
        m_ch[k]    = grant[k];
        if (mode) m_ptr[k] = (grant[k] + 1) % nch[k];
      end else if (m_valid[k] && out_ready) begin
        m_valid[k] = 1'b0;
      end
    end
    check_outputs(tag);
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = 3'd0;
    out_ready = 1'b1;
    in_valid8 = 8'hff;
    for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = 8'h10 + 8'(i);
    model_reset();

    // Reset held: nothing valid, nothing ready even with every channel offering data.
    #2;
    check("rst_v8", 32'(d8_out_valid), 32'd0);
    check("rst_rdy8", 32'(d8_in_ready), 32'd0);
    check("rst_rdy5", 32'(d5_in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_edge_rdy8", 32'(d8_in_ready), 32'd0);
    rst       = 1'b0;
    in_valid8 = 8'h00;
    step("idle");
    step("idle2");

    // Fixed mode.
    in_valid8 = 8'hff;
    sel       = 3'd3;
    step("fix3");
    check("fix3_data", 32'(d8_out_data), 32'h13);
    check("fix3_ch", 32'(d8_out_ch), 32'd3);
    sel = 3'd7;
    step("fix7");
    check("fix7_data", 32'(d8_out_data), 32'h17);
    check("fix7_ch", 32'(d8_out_ch), 32'd7);
    in_valid8 = 8'b0000_0100;
    step("fix7_noval");
    check("fix7_noval_v", 32'(d8_out_valid), 32'd0);

    // Round-robin, full load: no bubbles.
    mode      = 1'b1;
    in_valid8 = 8'hff;
    for (int i = 0; i < 9; i++) begin
      step("rr_full");
      check("rr_full_ch", 32'(d8_out_ch), 32'(i % 8));
      check("rr_full_v", 32'(d8_out_valid), 32'd1);
    end

    // Reset mid-stream with the register full.
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_v8", 32'(d8_out_valid), 32'd0);
    check("mid_rst_d8", 32'(d8_out_data), 32'd0);
    check("mid_rst_c8", 32'(d8_out_ch), 32'd0);
    check("mid_rst_rdy8", 32'(d8_in_ready), 32'd0);
    check("mid_rst_v5", 32'(d5_out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_edge_rdy5", 32'(d5_in_ready), 32'd0);
    rst       = 1'b0;
    in_valid8 = 8'h00;
    step("post_rst_idle");

    // Sparse round-robin: channels 1 and 4, pointer wraps 4 -> 0 on the N=5 instance.
    in_valid8 = 8'b0001_0010;
    for (int i = 0; i < 4; i++) begin
      step("rr_sparse");
      check("rr_sparse_ch5", 32'(d5_out_ch), (i % 2 == 0) ? 32'd1 : 32'd4);
    end
    mode = 1'b0;
    sel  = 3'd6;
    step("fix_sel6");

    // Backpressure: load, stall three cycles, then drain and reload on one edge.
    mode      = 1'b1;
    in_valid8 = 8'hff;
    step("bp_load");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("bp_hold");
    out_ready = 1'b1;
    step("bp_drain");

    // Mode switch with the register full.
    out_ready = 1'b0;
    step("ms_fill");
    mode = 1'b0;
    sel  = 3'd2;
    step("ms_hold");
    out_ready = 1'b1;
    step("ms_fixed");
    check("ms_fixed_ch8", 32'(d8_out_ch), 32'd2);
    mode = 1'b1;
    step("ms_rr_resume");
    step("ms_rr_next");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid8 = 8'($urandom);
      in_data8  = {$urandom, $urandom};
      mode      = 1'($urandom_range(0, 1));
      sel       = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
